// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a dc_fifo. A packet is granted only when the whole
// declared length fits in the FIFO. The grant stays locked until the packet ends.
module fifo_wr_arbiter #(
   parameter int unsigned REQ_CNT    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   input  logic [REQ_CNT-1:0]                  req_valid_i,
   input  logic [REQ_CNT*DATA_WIDTH-1:0]       req_data_i,
   input  logic [REQ_CNT-1:0]                  req_last_i,
   input  logic [REQ_CNT*(ADDR_WIDTH+1)-1:0]   req_len_i,
   output logic [REQ_CNT-1:0]                  req_ready_o,
   output logic                                fifo_wr_o,
   output logic [DATA_WIDTH-1:0]               fifo_wr_data_o,
   input  logic                                fifo_wr_full_i,
   input  logic [ADDR_WIDTH:0]                 fifo_wr_used_words_i,
   output logic [REQ_CNT-1:0]                  grant_o,
   output logic                                busy_o,
   output logic                                len_err_o
);

   localparam int unsigned LenW = ADDR_WIDTH + 1;
   localparam int unsigned PtrW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
   localparam logic [LenW-1:0] Cap = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e              state_q, state_d;
   logic [PtrW-1:0]     owner_q, owner_d;
   logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [LenW-1:0]     cnt_q, cnt_d;
   logic [REQ_CNT-1:0]  grant_q, grant_d;
   logic                len_err_q, len_err_d;

   logic [DATA_WIDTH-1:0] data_arr [REQ_CNT];
   logic [LenW-1:0]       len_arr  [REQ_CNT];
   logic [LenW-1:0]       free;
   logic                  win_found;
   logic [PtrW-1:0]       win_idx;
   logic [PtrW-1:0]       scan_idx;
   int unsigned           scan_pos;
   logic                  accept;
   logic                  cnt_one;
   logic                  end_word;

   // Unpack per-source data/length fields and compute free space (clamped at zero).
   always_comb begin
      for (int k = 0; k < int'(REQ_CNT); k++) begin
         data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         len_arr[k]  = req_len_i[k*LenW +: LenW];
      end
      free = (fifo_wr_used_words_i >= Cap) ? '0 : Cap - fifo_wr_used_words_i;
   end

   // Round-robin scan from rr_ptr for the first source whose whole packet fits.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_pos  = 0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < REQ_CNT; i++) begin
         scan_pos = (32'(rr_ptr_q) + i) % REQ_CNT;
         scan_idx = PtrW'(scan_pos);
         if (!win_found && req_valid_i[scan_idx] && (len_arr[scan_idx] != '0) &&
             (len_arr[scan_idx] <= free)) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign accept   = (state_q == StStream) && req_valid_i[owner_q] && !fifo_wr_full_i;
   assign cnt_one  = (cnt_q == LenW'(1));
   assign end_word = accept && (req_last_i[owner_q] || cnt_one);

   // Next-state: grant on a winner, count beats, end on last or exhausted length.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      len_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d          = StStream;
               owner_d          = win_idx;
               cnt_d            = len_arr[win_idx];
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
            end
         end
         StStream: begin
            if (accept) begin
               cnt_d = cnt_q - LenW'(1);
               if (end_word) begin
                  state_d   = StIdle;
                  grant_d   = '0;
                  rr_ptr_d  = (owner_q == PtrW'(REQ_CNT - 1)) ? '0 : owner_q + PtrW'(1);
                  // Error only when last and declared length disagree on the end word.
                  len_err_d = req_last_i[owner_q] ^ cnt_one;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous abort on reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         grant_q   <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         len_err_q <= len_err_d;
      end
   end

   // Owner's word passes straight through to the FIFO write port.
   always_comb begin
      req_ready_o    = '0;
      fifo_wr_o      = 1'b0;
      fifo_wr_data_o = data_arr[owner_q];
      if (state_q == StStream) begin
         req_ready_o[owner_q] = !fifo_wr_full_i;
         fifo_wr_o            = accept;
      end
   end

   assign grant_o   = grant_q;
   assign busy_o    = (state_q == StStream);
   assign len_err_o = len_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench: four packet sources and a FIFO occupancy model drive the arbiter;
// a packet-level reference model predicts every output each cycle.
module tb_fifo_wr_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int AW  = 3;
   localparam int CAP = 1 << AW;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_last;
   logic [N*(AW+1)-1:0] req_len;
   logic [N-1:0]      req_ready;
   logic              fifo_wr;
   logic [DW-1:0]     fifo_wr_data;
   logic              fifo_full;
   logic [AW:0]       fifo_used;
   logic [N-1:0]      grant;
   logic              busy;
   logic              len_err;

   fifo_wr_arbiter #(.REQ_CNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i               (clk),
      .rst_n_i             (rst_n),
      .req_valid_i         (req_valid),
      .req_data_i          (req_data),
      .req_last_i          (req_last),
      .req_len_i           (req_len),
      .req_ready_o         (req_ready),
      .fifo_wr_o           (fifo_wr),
      .fifo_wr_data_o      (fifo_wr_data),
      .fifo_wr_full_i      (fifo_full),
      .fifo_wr_used_words_i(fifo_used),
      .grant_o             (grant),
      .busy_o              (busy),
      .len_err_o           (len_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   // Source packets: actual words, declared length, progress and idle gap.
   logic [DW-1:0] words [N][$];
   int decl_len [N];
   int pos      [N];
   int gap      [N];

   // Reference model state: owner (-1 idle), rotation start, words left, pending error.
   int owner;
   int rr;
   int left_cnt;
   int lerr;
   int fifo_cnt;
   logic [N-1:0] exp_ready;
   logic         exp_wr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic new_packet(input int k);
      int n;
      int act;
      n   = 1 + int'($urandom % CAP);
      act = ($urandom % 4 == 0) ? 1 + int'($urandom % CAP) : n;
      words[k].delete();
      for (int i = 0; i < act; i++) words[k].push_back(DW'($urandom));
      decl_len[k] = n;
      pos[k]      = 0;
      gap[k]      = int'($urandom % 3);
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < N; k++) begin
         req_valid[k]               = (gap[k] == 0) && ($urandom % 5 != 0);
         req_data[k*DW +: DW]       = words[k][pos[k]];
         req_last[k]                = (pos[k] == words[k].size() - 1);
         req_len[k*(AW+1) +: AW+1]  = (AW+1)'(decl_len[k]);
      end
      fifo_used = (AW+1)'(fifo_cnt);
      fifo_full = (fifo_cnt == CAP) || ($urandom % 20 == 0);
   endtask

   // Compare DUT against the model for the current inputs, then advance everything.
   task automatic eval_cycle();
      logic [N-1:0] exp_grant;
      int free;
      int rd;
      int new_lerr;
      bit last;
      #1;
      exp_ready = '0;
      exp_wr    = 1'b0;
      exp_grant = '0;
      if (owner >= 0) begin
         exp_grant[owner] = 1'b1;
         if (!fifo_full) exp_ready[owner] = 1'b1;
         exp_wr = req_valid[owner] && !fifo_full;
      end
      check_eq("grant", 32'(grant), 32'(exp_grant));
      check_eq("busy", 32'(busy), 32'(owner >= 0));
      check_eq("len_err", 32'(len_err), 32'(lerr));
      check_eq("ready", 32'(req_ready), 32'(exp_ready));
      check_eq("wr", 32'(fifo_wr), 32'(exp_wr));
      if (exp_wr) check_eq("data", 32'(fifo_wr_data), 32'(words[owner][pos[owner]]));

      new_lerr = 0;
      if (owner < 0) begin
         free = CAP - fifo_cnt;
         for (int i = 0; i < N; i++) begin
            int k;
            k = (rr + i) % N;
            if (owner < 0 && req_valid[k] && decl_len[k] != 0 && decl_len[k] <= free) begin
               owner    = k;
               left_cnt = decl_len[k];
            end
         end
      end else if (exp_wr) begin
         last = (pos[owner] == words[owner].size() - 1);
         if (last || left_cnt == 1) begin
            new_lerr = (last != (left_cnt == 1)) ? 1 : 0;
            rr       = (owner + 1) % N;
            owner    = -1;
         end else begin
            left_cnt--;
         end
      end
      lerr = new_lerr;

      for (int k = 0; k < N; k++) begin
         if (gap[k] > 0) gap[k]--;
         else if (req_valid[k] && exp_ready[k]) begin
            pos[k]++;
            if (pos[k] == words[k].size()) new_packet(k);
         end
      end
      rd = (fifo_cnt > 0 && $urandom % 3 == 0) ? 1 : 0;
      fifo_cnt = fifo_cnt + int'(exp_wr) - rd;
   endtask

   task automatic run_cycle();
      @(negedge clk);
      drive_inputs();
      eval_cycle();
   endtask

   initial begin
      rst_n    = 1'b0;
      owner    = -1;
      rr       = 0;
      left_cnt = 0;
      lerr     = 0;
      fifo_cnt = 0;
      for (int k = 0; k < N; k++) new_packet(k);
      drive_inputs();
      #2;
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_wr", 32'(fifo_wr), 32'd0);
      check_eq("rst_len_err", 32'(len_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      eval_cycle();

      for (int c = 0; c < 3000; c++) run_cycle();

      // Wait for a packet in flight, then abort it with an off-edge reset.
      for (int i = 0; i < 300 && owner < 0; i++) run_cycle();
      check_eq("found_packet_for_reset", 32'(owner >= 0), 32'd1);
      @(negedge clk);
      drive_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("abort_grant", 32'(grant), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_ready", 32'(req_ready), 32'd0);
      check_eq("abort_wr", 32'(fifo_wr), 32'd0);
      check_eq("abort_len_err", 32'(len_err), 32'd0);
      owner = -1;
      rr    = 0;
      lerr  = 0;
      @(negedge clk);
      rst_n = 1'b1;
      eval_cycle();

      for (int c = 0; c < 1500; c++) run_cycle();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
